// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory port served by mem_arbiter.
// The slave side is the arbiter; the master side drives requests and returns memory read data.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SPACE = 14
);
   logic                  r0_req;
   logic                  r0_we;
   logic [ADDR_SPACE-1:0] r0_addr;
   logic [DATA_WIDTH-1:0] r0_wdata;
   logic                  r0_gnt;
   logic                  r0_rvalid;
   logic [DATA_WIDTH-1:0] r0_rdata;

   logic                  r1_req;
   logic                  r1_we;
   logic [ADDR_SPACE-1:0] r1_addr;
   logic [DATA_WIDTH-1:0] r1_wdata;
   logic                  r1_gnt;
   logic                  r1_rvalid;
   logic [DATA_WIDTH-1:0] r1_rdata;

   logic [ADDR_SPACE-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_out;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      input  mem_out,
      output r0_gnt, r0_rvalid, r0_rdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_addr, mem_data, mem_we
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      output mem_out,
      input  r0_gnt, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory with bounded bursts (BURST grants max while
// the other side waits) and a registered read-return path one cycle after the read grant.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SPACE = 14,
   parameter int BURST      = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(BURST + 1);

   typedef enum logic {
      ID_R0 = 1'b0,
      ID_R1 = 1'b1
   } req_id_e;

   req_id_e               owner, owner_nxt;
   req_id_e               pend_id, pend_id_nxt;
   req_id_e               winner;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  pend, pend_nxt;
   logic                  any_req;
   logic                  grant;
   logic                  win_we;
   logic [ADDR_SPACE-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;

   assign any_req = bus.r0_req | bus.r1_req;
   assign grant   = any_req & ~rst;

   // Under contention the owner keeps the port only while its burst is open (0 < cnt < BURST).
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      winner = ID_R0;
      if (bus.r0_req && bus.r1_req) begin
         if (cnt != '0 && cnt < CNT_W'(BURST)) winner = owner;
         else                                  winner = (owner == ID_R0) ? ID_R1 : ID_R0;
      end else if (bus.r1_req) begin
         winner = ID_R1;
      end
   end

   always_comb begin
      win_we   = bus.r0_we;
      win_addr = bus.r0_addr;
      win_data = bus.r0_wdata;
      if (winner == ID_R1) begin
         win_we   = bus.r1_we;
         win_addr = bus.r1_addr;
         win_data = bus.r1_wdata;
      end
   end

   assign bus.r0_gnt   = grant && (winner == ID_R0);
   assign bus.r1_gnt   = grant && (winner == ID_R1);
   assign bus.mem_we   = grant & win_we;
   assign bus.mem_addr = grant ? win_addr : '0;
   assign bus.mem_data = grant ? win_data : '0;

   always_comb begin
      owner_nxt   = owner;
      cnt_nxt     = cnt;
      pend_nxt    = 1'b0;
      pend_id_nxt = pend_id;
      if (any_req) begin
         if (winner == owner && cnt != '0) begin
            if (cnt != CNT_W'(BURST)) cnt_nxt = cnt + CNT_W'(1);
         end else begin
            owner_nxt = winner;
            cnt_nxt   = CNT_W'(1);
         end
         pend_nxt    = ~win_we;
         pend_id_nxt = winner;
      end else begin
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
      if (rst) begin
         owner   <= ID_R1;
         cnt     <= '0;
         pend    <= 1'b0;
         pend_id <= ID_R0;
      end else begin
         owner   <= owner_nxt;
         cnt     <= cnt_nxt;
         pend    <= pend_nxt;
         pend_id <= pend_id_nxt;
      end
   end

   // A read granted just before rst rises is suppressed in the rst cycle as well.
   assign bus.r0_rvalid = pend && (pend_id == ID_R0) && !rst;
   assign bus.r1_rvalid = pend && (pend_id == ID_R1) && !rst;
   assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_out : '0;
   assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_out : '0;
endmodule
